// File: rtl/lza_norm_shift_if.sv
// ----------------------------------------------------------------------------
// lza_norm_shift_if
// Bundles the upstream (valid_i/ready_o/sum_i/exp_i) and downstream
// (valid_o/ready_i/norm_sum_o/exp_o/lzc_o/zero_o/underflow_o) handshakes of
// the normalisation stage.
//   slave  : seen by lza_norm_shift (consumes sum/exp, produces results)
//   master : seen by whatever drives the stage and consumes its results
// Parameters:
//   SW  significand width
//   EW  biased exponent width
//   LW  leading-zero count width, derived from SW
// ----------------------------------------------------------------------------
interface lza_norm_shift_if #(
  parameter int SW = 26,
  parameter int EW = 8
);
  localparam int LW = $clog2(SW + 1);

  logic          valid_i;
  logic          ready_o;
  logic [SW-1:0] sum_i;
  logic [EW-1:0] exp_i;
  logic          valid_o;
  logic          ready_i;
  logic [SW-1:0] norm_sum_o;
  logic [EW-1:0] exp_o;
  logic [LW-1:0] lzc_o;
  logic          zero_o;
  logic          underflow_o;

  modport master (
    output valid_i, sum_i, exp_i, ready_i,
    input  ready_o, valid_o, norm_sum_o, exp_o, lzc_o, zero_o, underflow_o
  );

  modport slave (
    input  valid_i, sum_i, exp_i, ready_i,
    output ready_o, valid_o, norm_sum_o, exp_o, lzc_o, zero_o, underflow_o
  );
endinterface

// File: rtl/lza_norm_shift.sv
// ----------------------------------------------------------------------------
// lza_norm_shift
// Normalisation stage after the significand adder. Counts leading zeros of
// the raw sum, left-shifts it so the MSB is set and lowers the exponent by
// the shift, clamping at exponent 0 (denormal result). Two register stages
// with valid/ready on both sides; throughput one item per cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low; flushes both stages
//   bus    lza_norm_shift_if.slave
//            valid_i/ready_o/sum_i/exp_i                  input handshake
//            valid_o/ready_i/norm_sum_o/exp_o/lzc_o/
//            zero_o/underflow_o                           output handshake
// SW/EW must match the parameters of the connected interface instance.
// ----------------------------------------------------------------------------
module lza_norm_shift #(
  parameter int SW = 26,
  parameter int EW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  lza_norm_shift_if.slave   bus
);
  localparam int LW = $clog2(SW + 1);
  // common width for comparing the zero count against the exponent
  localparam int XW = (LW > EW) ? LW : EW;

  // Leading-zero count scanning from the MSB; an all-zero word yields SW.
  function automatic logic [LW-1:0] count_lz(input logic [SW-1:0] v);
    logic [LW-1:0] n;
    logic          done;
    n    = '0;
    done = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!done) begin
        if (v[i]) begin
          done = 1'b1;
        end else begin
          n = n + LW'(1'b1);
        end
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // stage 1 registers
  logic          s1_valid_r;
  logic [SW-1:0] s1_sum_r;
  logic [EW-1:0] s1_exp_r;
  logic [LW-1:0] s1_lzc_r;

  // stage 2 registers (drive the outputs directly)
  logic          s2_valid_r;
  logic [SW-1:0] s2_sum_r;
  logic [EW-1:0] s2_exp_r;
  logic [LW-1:0] s2_lzc_r;
  logic          s2_zero_r;
  logic          s2_uf_r;

  // handshake and datapath combinational signals
  logic          s2_load_s;
  logic          ready_s;
  logic [LW-1:0] lzc_in_s;
  logic          zero_s;
  logic          uf_s;
  logic [XW-1:0] lzc_x_s;
  logic [XW-1:0] exp_x_s;
  logic [XW-1:0] shift_s;
  logic [EW-1:0] exp_adj_s;
  logic [SW-1:0] norm_s;

  // Handshake: S2 frees up when empty or being drained; S1 when empty or
  // moving into S2. ready_o is therefore combinational in ready_i.
  always_comb begin
    s2_load_s = ~s2_valid_r | bus.ready_i;
    ready_s   = ~s1_valid_r | s2_load_s;
  end

  // Leading-zero count of the incoming sum, registered in S1.
  always_comb begin
    lzc_in_s = count_lz(bus.sum_i);
  end

  // Shift/exponent decision for the item sitting in S1.
  always_comb begin
    zero_s    = (s1_sum_r == {SW{1'b0}});
    lzc_x_s   = XW'(s1_lzc_r);
    exp_x_s   = XW'(s1_exp_r);
    shift_s   = '0;
    exp_adj_s = '0;
    uf_s      = 1'b0;
    if (zero_s) begin
      shift_s   = '0;
      exp_adj_s = '0;
      uf_s      = 1'b0;
    end else if (lzc_x_s < exp_x_s) begin
      // full normalisation fits; lzc < exp so it fits in EW bits
      shift_s   = lzc_x_s;
      exp_adj_s = s1_exp_r - EW'(s1_lzc_r);
      uf_s      = 1'b0;
    end else begin
      // exponent runs out first: shift only down to exponent 0 (denormal),
      // which also covers exp=0 (no shift at all)
      shift_s   = exp_x_s;
      exp_adj_s = '0;
      uf_s      = 1'b1;
    end
    norm_s = s1_sum_r << shift_s;
  end

  // Stage 1 capture: loads whenever the stage is ready to take input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sum_r   <= '0;
      s1_exp_r   <= '0;
      s1_lzc_r   <= '0;
    end else if (ready_s) begin
      s1_valid_r <= bus.valid_i;
      if (bus.valid_i) begin
        s1_sum_r <= bus.sum_i;
        s1_exp_r <= bus.exp_i;
        s1_lzc_r <= lzc_in_s;
      end
    end
  end

  // Stage 2 capture: holds its contents while valid_o & ~ready_i.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_sum_r   <= '0;
      s2_exp_r   <= '0;
      s2_lzc_r   <= '0;
      s2_zero_r  <= 1'b0;
      s2_uf_r    <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_sum_r  <= norm_s;
        s2_exp_r  <= exp_adj_s;
        s2_lzc_r  <= s1_lzc_r;
        s2_zero_r <= zero_s;
        s2_uf_r   <= uf_s;
      end
    end
  end

  assign bus.ready_o     = ready_s;
  assign bus.valid_o     = s2_valid_r;
  assign bus.norm_sum_o  = s2_sum_r;
  assign bus.exp_o       = s2_exp_r;
  assign bus.lzc_o       = s2_lzc_r;
  assign bus.zero_o      = s2_zero_r;
  assign bus.underflow_o = s2_uf_r;
endmodule
